// File: rtl/pmem_adapter_pkg.sv
// Shared definitions for the L2 physical-memory burst adapter.
//   S_LINE   : L2 line width in bits
//   S_BURST  : memory beat width in bits
//   S_BEATS  : beats per line burst
//   S_OFFSET : line-offset address bits cleared on the memory side
//   pmem_state_e : adapter FSM states
package pmem_adapter_pkg;

    localparam int unsigned S_LINE   = 256;
    localparam int unsigned S_BURST  = 64;
    localparam int unsigned S_BEATS  = S_LINE / S_BURST;
    localparam int unsigned S_OFFSET = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } pmem_state_e;

endpackage

// File: rtl/pmem_burst_adapter.sv
// Converts single-line L2 read/write requests into fixed-length beat bursts on
// the main-memory side and reassembles read bursts into a line.
//
// Ports (L2 side):
//   pmem_read / pmem_write : line request, held by L2 until pmem_resp
//   pmem_address           : line address
//   pmem_wdata             : write line
//   pmem_rdata             : last completed read line
//   pmem_resp              : one-cycle completion pulse
// Ports (memory side):
//   address_o              : line-aligned burst address
//   read_o / write_o       : burst request (mutually exclusive)
//   burst_o                : current write beat
//   burst_i                : incoming read beat
//   resp_i                 : beat strobe, one beat per high cycle
// Reset (rst) is synchronous and active-high; all outputs reset to zero.
module pmem_burst_adapter
    import pmem_adapter_pkg::*;
#(
    parameter int unsigned s_line   = S_LINE,
    parameter int unsigned s_burst  = S_BURST,
    parameter int unsigned s_offset = S_OFFSET
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [31:0]         pmem_address,
    input  logic [s_line-1:0]   pmem_wdata,
    output logic [s_line-1:0]   pmem_rdata,
    output logic                pmem_resp,

    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    output logic [s_burst-1:0]  burst_o,
    input  logic [s_burst-1:0]  burst_i,
    input  logic                resp_i
);

    localparam int unsigned s_beats = s_line / s_burst;
    localparam int unsigned CntW    = (s_beats > 1) ? $clog2(s_beats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(s_beats - 1);
    localparam logic [31:0]     OffMask  = 32'((64'd1 << s_offset) - 64'd1);

    pmem_state_e        state_q;
    logic [CntW-1:0]    cnt_q;
    logic [31:0]        addr_q;
    logic [s_line-1:0]  line_q;
    logic [s_line-1:0]  rdata_q;
    logic               read_q;
    logic               write_q;
    logic               resp_q;

    // Line buffer with the incoming read beat dropped into the current slot.
    // Reads assemble in line_q so pmem_rdata only changes once the burst is whole.
    logic [s_line-1:0]  line_merged;

    always_comb begin
        line_merged = line_q;
        line_merged[cnt_q*s_burst +: s_burst] = burst_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Write wins so a dirty writeback goes out ahead of the fill.
                    if (pmem_write) begin
                        addr_q  <= pmem_address & ~OffMask;
                        line_q  <= pmem_wdata;
                        cnt_q   <= '0;
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end else if (pmem_read) begin
                        addr_q  <= pmem_address & ~OffMask;
                        cnt_q   <= '0;
                        read_q  <= 1'b1;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (resp_i) begin
                        line_q <= line_merged;
                        if (cnt_q == LastBeat) begin
                            rdata_q <= line_merged;
                            cnt_q   <= '0;
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (resp_i) begin
                        if (cnt_q == LastBeat) begin
                            cnt_q   <= '0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;
    assign address_o  = addr_q;
    assign read_o     = read_q;
    assign write_o    = write_q;
    // Gated so the bus is quiet outside a write burst.
    assign burst_o    = write_q ? line_q[cnt_q*s_burst +: s_burst] : '0;

endmodule
